// File: rtl/piece_queue.sv
//==============================================================================
// Module      : piece_queue
// Description : Tetromino source for the hold/swap and spawn logic. A 16-bit
//               Fibonacci LFSR proposes candidate types; accepted candidates
//               fill a small shift queue (current piece + previews). The
//               current piece is also presented as two 10-bit spawn-row masks.
//               Optional feature macro: PIECE_QUEUE_BAG_EN (7-bag randomizer).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module piece_queue #(
    parameter int          DEPTH = 4,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pop,
    output logic                   ready,
    output logic [2:0]             cur_type,
    output logic [1:0][9:0]        cur_block,
    output logic [DEPTH-2:0][2:0]  next_type
);

    localparam int             CW          = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  C_FULL      = CW'(DEPTH);
    localparam logic [CW-1:0]  C_AFTER_POP = CW'(DEPTH - 1);
    localparam logic [2:0]     C_NONE      = 3'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [15:0]             r_lfsr;
    logic                    w_fb;
    logic [DEPTH-1:0][2:0]   r_q;
    logic [DEPTH-1:0][2:0]   w_q_next;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           w_count_next;
    logic [2:0]              w_cand;
    logic                    w_accept;

`ifdef PIECE_QUEUE_BAG_EN
    logic [6:0]              r_bag;
    logic [6:0]              w_bag_next;
    logic [6:0]              w_cand_oh;
    logic [6:0]              w_bag_set;
`endif

    // The low three LFSR bits are the draw candidate; 7 is never a legal type.
    assign w_cand = r_lfsr[2:0];
    assign w_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // LFSR free-runs every non-reset cycle so rejected draws retry with a new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    // State, queue, count and bag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_count <= '0;
            r_q     <= {DEPTH{C_NONE}};
`ifdef PIECE_QUEUE_BAG_EN
            r_bag   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_q     <= w_q_next;
`ifdef PIECE_QUEUE_BAG_EN
            r_bag   <= w_bag_next;
`endif
        end
    end

    // Next-state logic: FILL appends accepted draws, IDLE waits for a pop.
    // A pop can only land in IDLE (queue full), so draws and pops never overlap.
    always_comb begin
        w_q_next     = r_q;
        w_count_next = r_count;
        w_accept     = 1'b0;
`ifdef PIECE_QUEUE_BAG_EN
        w_bag_next   = r_bag;
        w_cand_oh    = 7'd1 << w_cand;
        w_bag_set    = r_bag | w_cand_oh;
`endif
        case (r_state)
            FILL: begin
`ifdef PIECE_QUEUE_BAG_EN
                w_accept = (w_cand != C_NONE) && ((r_bag & w_cand_oh) == 7'd0);
`else
                w_accept = (w_cand != C_NONE);
`endif
                if (w_accept) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (r_count == CW'(k)) begin
                            w_q_next[k] = w_cand;
                        end
                    end
                    w_count_next = r_count + CW'(1);
`ifdef PIECE_QUEUE_BAG_EN
                    // A completed bag empties in the same cycle it fills.
                    w_bag_next = (w_bag_set == 7'h7F) ? 7'd0 : w_bag_set;
`endif
                end
            end
            IDLE: begin
                if (pop) begin
                    for (int k = 0; k < DEPTH - 1; k++) begin
                        w_q_next[k] = r_q[k+1];
                    end
                    w_q_next[DEPTH-1] = C_NONE;
                    w_count_next      = C_AFTER_POP;
                end
            end
            default: begin
                w_count_next = r_count;
            end
        endcase
        w_state_next = (w_count_next < C_FULL) ? FILL : IDLE;
    end

    // Outputs decode registered state only; pop never reaches them combinationally.
    assign ready    = (r_count == C_FULL);
    assign cur_type = (r_count != '0) ? r_q[0] : C_NONE;

    generate
        for (genvar k = 0; k < DEPTH - 1; k++) begin : g_next
            assign next_type[k] = (r_count > CW'(k + 1)) ? r_q[k+1] : C_NONE;
        end
    endgenerate

    // Spawn-row masks of the current piece; cur_block[0] is the top row.
    always_comb begin
        cur_block = '0;
        case (cur_type)
            3'd0: begin cur_block[0] = 10'h078; cur_block[1] = 10'h000; end
            3'd1: begin cur_block[0] = 10'h030; cur_block[1] = 10'h030; end
            3'd2: begin cur_block[0] = 10'h010; cur_block[1] = 10'h038; end
            3'd3: begin cur_block[0] = 10'h030; cur_block[1] = 10'h018; end
            3'd4: begin cur_block[0] = 10'h018; cur_block[1] = 10'h030; end
            3'd5: begin cur_block[0] = 10'h008; cur_block[1] = 10'h038; end
            3'd6: begin cur_block[0] = 10'h020; cur_block[1] = 10'h038; end
            default: begin cur_block[0] = 10'h000; cur_block[1] = 10'h000; end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_piece_queue.sv
//==============================================================================
// Module      : tb_piece_queue
// Description : Scoreboard bench for piece_queue. A queue-level reference model
//               predicts every cycle's outputs; a monitor compares them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_piece_queue;

    localparam int          DEPTH = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef PIECE_QUEUE_BAG_EN
    localparam bit BAG      = 1'b1;
    localparam int FIRST_N  = 5;
`else
    localparam bit BAG      = 1'b0;
    localparam int FIRST_N  = 4;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pop;
    logic                  ready;
    logic [2:0]            cur_type;
    logic [1:0][9:0]       cur_block;
    logic [DEPTH-2:0][2:0] next_type;

    piece_queue #(.DEPTH(DEPTH), .SEED(SEED)) dut (
        .clk       (clk),
        .reset     (reset),
        .pop       (pop),
        .ready     (ready),
        .cur_type  (cur_type),
        .cur_block (cur_block),
        .next_type (next_type)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                  rdy;
        logic [2:0]            ct;
        logic [9:0]            r0;
        logic [9:0]            r1;
        logic [DEPTH-2:0][2:0] nt;
    } snap_t;

    snap_t exp_q[$];
    int    consumed[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model state: plain LFSR value, SV queue of types, bag as a set.
    logic [15:0] m_lfsr;
    int          m_q[$];
    bit   [6:0]  m_bag;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return (l >> 1) | (16'(fb) << 15);
    endfunction

    function automatic logic [9:0] shape_row(input logic [2:0] t, input bit top);
        logic [9:0] a, b;
        case (t)
            3'd0: begin a = 10'h078; b = 10'h000; end
            3'd1: begin a = 10'h030; b = 10'h030; end
            3'd2: begin a = 10'h010; b = 10'h038; end
            3'd3: begin a = 10'h030; b = 10'h018; end
            3'd4: begin a = 10'h018; b = 10'h030; end
            3'd5: begin a = 10'h008; b = 10'h038; end
            3'd6: begin a = 10'h020; b = 10'h038; end
            default: begin a = 10'h000; b = 10'h000; end
        endcase
        return top ? a : b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Model: advances on each edge with the same inputs the DUT sees, then
    // pushes the outputs it expects to be visible after that edge.
    always @(posedge clk) begin
        snap_t e;
        int    c;
        if (reset) begin
            m_lfsr = SEED;
            m_q.delete();
            m_bag  = '0;
        end else begin
            if (m_q.size() == DEPTH) begin
                if (pop) void'(m_q.pop_front());
            end else begin
                c = int'(m_lfsr % 16'd8);
                if (c != 7 && !(BAG && m_bag[c])) begin
                    m_q.push_back(c);
                    if (BAG) begin
                        m_bag[c] = 1'b1;
                        if (m_bag == 7'h7F) m_bag = '0;
                    end
                end
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
        e.rdy = (m_q.size() == DEPTH);
        e.ct  = (m_q.size() > 0) ? 3'(m_q[0]) : 3'd7;
        e.r0  = shape_row(e.ct, 1'b1);
        e.r1  = shape_row(e.ct, 1'b0);
        for (int k = 0; k < DEPTH - 1; k++) begin
            e.nt[k] = (m_q.size() > k + 1) ? 3'(m_q[k+1]) : 3'd7;
        end
        exp_q.push_back(e);
    end

    // Monitor: compares DUT outputs against the oldest prediction, and logs
    // every piece the DUT hands over (ready and pop together).
    always @(negedge clk) begin
        snap_t got, want;
        got.rdy = ready;
        got.ct  = cur_type;
        got.r0  = cur_block[0];
        got.r1  = cur_block[1];
        got.nt  = next_type;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cycle_state: got rdy=%0d cur=%0d r0=%h r1=%h nxt=%h expected rdy=%0d cur=%0d r0=%h r1=%h nxt=%h at %0t",
                         got.rdy, got.ct, got.r0, got.r1, got.nt,
                         want.rdy, want.ct, want.r0, want.r1, want.nt, $time);
            end
        end
        if (ready === 1'b1 && pop === 1'b1) consumed.push_back(int'(cur_type));
    end

    // Entered at posedge+1 with reset high; releases reset and checks the
    // fixed opening sequence from SEED.
    task automatic run_first(input bit pop_fill);
        reset = 1'b0;
        pop   = pop_fill;
        repeat (FIRST_N - 1) @(posedge clk);
        @(negedge clk);
        chk("ready_before_full", 32'(ready), 32'd0);
        @(posedge clk);
        #1 pop = 1'b0;
        @(negedge clk);
        chk("ready_at_full", 32'(ready), 32'd1);
        chk("first_cur", 32'(cur_type), 32'd1);
        chk("first_row0", 32'(cur_block[0]), 32'h030);
        chk("first_row1", 32'(cur_block[1]), 32'h030);
        chk("first_next0", 32'(next_type[0]), 32'd0);
        chk("first_next1", 32'(next_type[1]), BAG ? 32'd4 : 32'd0);
        chk("first_next2", 32'(next_type[2]), BAG ? 32'd6 : 32'd4);
    endtask

    initial begin
        bit [6:0] seen;
        reset = 1'b1;
        pop   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_cur", 32'(cur_type), 32'd7);
        chk("reset_block", 32'(cur_block), 32'd0);
        chk("reset_next", 32'(next_type), 32'h1FF);
        @(posedge clk);
        #1;
        run_first(1'b0);

        // Honoured pop: head leaves, refill pending.
        @(posedge clk);
        #1 pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
        @(negedge clk);
        chk("pop_cur", 32'(cur_type), 32'd0);
        chk("pop_row0", 32'(cur_block[0]), 32'h078);
        chk("pop_row1", 32'(cur_block[1]), 32'h000);
        chk("pop_next0", 32'(next_type[0]), BAG ? 32'd4 : 32'd0);
        chk("pop_next1", 32'(next_type[1]), BAG ? 32'd6 : 32'd4);
        chk("pop_ready", 32'(ready), 32'd0);

        // Reset mid-fill with two pieces queued.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midfill_cur", 32'(cur_type), 32'd1);
        chk("midfill_next0", 32'(next_type[0]), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_cur", 32'(cur_type), 32'd7);
        chk("midrst_block", 32'(cur_block), 32'd0);
        @(posedge clk);
        #1;
        // Replay with pop asserted while not ready: must be ignored.
        run_first(1'b1);

        // Fresh start, then pop held high, then random pops.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        consumed.delete();
        @(posedge clk);
        #1 begin
            reset = 1'b0;
            pop   = 1'b1;
        end
        repeat (700) @(posedge clk);
        repeat (300) begin
            #1 pop = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        #1 pop = 1'b0;
        repeat (3) @(negedge clk);

        chk("consumed_enough", 32'(consumed.size() >= 50), 32'd1);
        if (BAG) begin
            for (int g = 0; g + 7 <= consumed.size(); g += 7) begin
                seen = '0;
                for (int i = 0; i < 7; i++) begin
                    if (consumed[g+i] >= 0 && consumed[g+i] < 7) seen[consumed[g+i]] = 1'b1;
                end
                chk("bag_perm", 32'(seen), 32'h7F);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
